// File: rtl/uart_tx_feeder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_feeder_pkg : shared defaults, FSM encoding and width helper
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_tx_feeder_pkg;

  localparam int c_DATA_W_DEF  = 8;
  // One 10-bit frame at 50 MHz / 115200 is about 4340 cycles; leave ample margin.
  localparam int c_TMO_CYC_DEF = 8192;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sync_fifo : single-clock FIFO with registered flags and read data
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wr_dat,
  input  logic              i_rd,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level,
  output logic              o_overflow,
  output logic [DATA_W-1:0] o_rd_dat
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rd_dat;

  logic              w_wr;
  logic              w_rd;
  logic [AW:0]       w_count_nxt;

  assign w_wr = i_wr && !r_full;
  assign w_rd = i_rd && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  // Flags follow the next count so they are valid on the same edge as the level.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_rd_dat   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_dat <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= i_wr && r_full;
    end
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_count;
  assign o_overflow = r_overflow;
  assign o_rd_dat   = r_rd_dat;

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_feeder : FIFO-buffered byte sequencer feeding the UART transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W_DEF,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int GAP_CYC = 0,
  parameter int TMO_CYC = c_TMO_CYC_DEF
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_dat,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level,
  output logic              o_overflow,
  output logic [DATA_W-1:0] o_tx_dat,
  output logic              o_tx_en,
  input  logic              i_tx_over,
  output logic              o_busy,
  output logic              o_tx_timeout
);

  localparam int GW = cnt_w(GAP_CYC + 1);
  localparam int WW = cnt_w(TMO_CYC);
  localparam logic [GW-1:0] c_GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [WW-1:0] c_WDOG_LAST = WW'(TMO_CYC - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gap_cnt;
  logic [WW-1:0] r_wdog;
  logic          r_tx_en;
  logic          w_pop;
  logic          w_timeout;
  logic          w_empty;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .i_wr       (i_wr_en),
    .i_wr_dat   (i_wr_dat),
    .i_rd       (w_pop),
    .o_full     (o_full),
    .o_empty    (w_empty),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .o_rd_dat   (o_tx_dat)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // An abandoned byte leaves WAIT exactly as a completed one would.
        w_timeout = (r_wdog == c_WDOG_LAST) && !i_tx_over;
        if (i_tx_over || w_timeout)
          w_state_nxt = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      r_wdog    <= '0;
      r_tx_en   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx_en <= w_pop;
      if (r_state == ST_START)
        r_wdog <= '0;
      else if (r_state == ST_WAIT && r_wdog != c_WDOG_LAST)
        r_wdog <= r_wdog + WW'(1);
      if (r_state == ST_WAIT)
        r_gap_cnt <= '0;
      else if (r_state == ST_GAP && r_gap_cnt != c_GAP_LAST)
        r_gap_cnt <= r_gap_cnt + GW'(1);
    end
  end

  assign o_empty      = w_empty;
  assign o_tx_en      = r_tx_en;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_tx_timeout = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_feeder : scoreboard bench over three feeder configurations
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_feeder;

  logic clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  logic            rst;
  logic [2:0]      wr_en;
  logic [7:0]      wr_dat;
  logic [2:0]      full, empty, overflow, tx_en, tx_over, busy, timeout;
  logic [2:0][4:0] level;
  logic [2:0][7:0] tx_dat;

  // Instance 0: no gap, long watchdog. 1: no gap, TMO 64. 2: gap 10, TMO 64.
  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      uart_tx_feeder #(
        .DATA_W  (8),
        .DEPTH   (16),
        .AW      (4),
        .GAP_CYC ((k == 2) ? 10 : 0),
        .TMO_CYC ((k == 0) ? 8192 : 64)
      ) u_dut (
        .clk_ref      (clk_ref),
        .rst          (rst),
        .i_wr_en      (wr_en[k]),
        .i_wr_dat     (wr_dat),
        .o_full       (full[k]),
        .o_empty      (empty[k]),
        .o_level      (level[k]),
        .o_overflow   (overflow[k]),
        .o_tx_dat     (tx_dat[k]),
        .o_tx_en      (tx_en[k]),
        .i_tx_over    (tx_over[k]),
        .o_busy       (busy[k]),
        .o_tx_timeout (timeout[k])
      );
    end
  endgenerate

  // Transmitter model: send-over arrives lat cycles after the start strobe (0 = never).
  logic [1:0] act = 2'd0;
  int         lat = 0;
  int         rem = 0;
  logic       model_over = 1'b0;
  logic       spur = 1'b0;

  assign tx_over = (model_over || spur) ? (3'b001 << act) : 3'b000;

  always @(posedge clk_ref) begin
    model_over <= 1'b0;
    if (tx_en[act] && lat > 0) rem <= lat;
    else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1) model_over <= 1'b1;
    end
  end

  typedef struct {
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_evt = 0;
  int   last_start = 0;
  int   n_start = 0;
  bit   evt_now = 0;

  function automatic int gap_of(input logic [1:0] k);
    return (k == 2'd2) ? 10 : 0;
  endfunction

  // Advance one clock, sample 1 time unit later, and score any start strobe.
  task automatic tick();
    exp_t e;
    int   want;
    @(posedge clk_ref);
    #1;
    cyc++;
    evt_now = 0;
    if (tx_en[act]) begin
      n_start++;
      last_start = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: tx_en with tx_dat=%h at cycle %0d, required no start", tx_dat[act], cyc);
      end else begin
        e = sb.pop_front();
        want = (e.cyc >= 0) ? e.cyc : last_evt + 2 + gap_of(act);
        if (tx_dat[act] !== e.dat) begin
          errors++;
          $display("FAIL start_data: got %h, required %h", tx_dat[act], e.dat);
        end
        checks++;
        if (cyc != want) begin
          errors++;
          $display("FAIL start_cycle: byte %h started at %0d, required %0d", e.dat, cyc, want);
        end
      end
    end
    if (model_over || timeout[act]) begin
      last_evt = cyc;
      evt_now  = 1;
    end
  endtask

  // mode 0: not expected on the wire, 1: start 2 cycles after write, 2: after prior frame end
  task automatic put_byte(input logic [7:0] d, input int mode);
    exp_t e;
    wr_dat = d;
    wr_en  = 3'b000;
    wr_en[act] = 1'b1;
    e.dat = d;
    e.cyc = (mode == 1) ? cyc + 2 : -1;
    if (mode != 0) sb.push_back(e);
    tick();
    wr_en = 3'b000;
  endtask

  task automatic wait_evt(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (evt_now) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no end of frame within %0d cycles, required one", name, budget);
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sb.size() == 0 && !busy[act]) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: %0d bytes still pending, required 0", name, sb.size());
  endtask

  task automatic test_reset();
    act = 2'd0; lat = 0; rst = 1'b1; wr_en = 3'b000; wr_dat = 8'h00; spur = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (full     !== 3'b000) begin errors++; $display("FAIL rst_full: got %b, required 000", full); end
    checks++; if (empty    !== 3'b111) begin errors++; $display("FAIL rst_empty: got %b, required 111", empty); end
    checks++; if (level    !== '0)     begin errors++; $display("FAIL rst_level: got %h, required 0", level); end
    checks++; if (overflow !== 3'b000) begin errors++; $display("FAIL rst_overflow: got %b, required 000", overflow); end
    checks++; if (tx_dat   !== '0)     begin errors++; $display("FAIL rst_tx_dat: got %h, required 0", tx_dat); end
    checks++; if (tx_en    !== 3'b000) begin errors++; $display("FAIL rst_tx_en: got %b, required 000", tx_en); end
    checks++; if (busy     !== 3'b000) begin errors++; $display("FAIL rst_busy: got %b, required 000", busy); end
    checks++; if (timeout  !== 3'b000) begin errors++; $display("FAIL rst_timeout: got %b, required 000", timeout); end
  endtask

  task automatic test_single();
    int s0;
    act = 2'd0; lat = 4340; s0 = n_start;
    put_byte(8'hA5, 1);
    wait_evt(4400, "single_over");
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_hi: got %b, required 1", busy[0]); end
    tick();
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_lo: got %b, required 0", busy[0]); end
    repeat (5) tick();
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL single_starts: got %0d, required 1", n_start - s0); end
    checks++; if (tx_dat[0] !== 8'hA5) begin errors++; $display("FAIL single_dat_hold: got %h, required a5", tx_dat[0]); end
  endtask

  task automatic test_burst();
    act = 2'd0; lat = 40;
    put_byte(8'h5A, 1);
    for (int i = 0; i < 16; i++) put_byte(8'(i), 2);
    checks++; if (level[0] !== 5'd16) begin errors++; $display("FAIL burst_level: got %0d, required 16", level[0]); end
    checks++; if (full[0] !== 1'b1)   begin errors++; $display("FAIL burst_full: got %b, required 1", full[0]); end
    checks++; if (empty[0] !== 1'b0)  begin errors++; $display("FAIL burst_empty: got %b, required 0", empty[0]); end
  endtask

  task automatic test_overflow();
    put_byte(8'hFF, 0);
    checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b, required 1", overflow[0]); end
    checks++; if (level[0] !== 5'd16)   begin errors++; $display("FAIL ovf_level: got %0d, required 16", level[0]); end
    tick();
    checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL ovf_single: got %b, required 0", overflow[0]); end
    // Dropped write landing on the same edge as a pop.
    wait_evt(60, "ovf_over0");
    tick();
    put_byte(8'hFF, 0);
    checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_pop_pulse: got %b, required 1", overflow[0]); end
    checks++; if (level[0] !== 5'd15)   begin errors++; $display("FAIL ovf_pop_level: got %0d, required 15", level[0]); end
    // Accepted write on the same edge as a pop keeps the level.
    wait_evt(60, "ovf_over1");
    tick();
    put_byte(8'h10, 2);
    checks++; if (level[0] !== 5'd15)   begin errors++; $display("FAIL wrpop_level: got %0d, required 15", level[0]); end
    checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL wrpop_ovf: got %b, required 0", overflow[0]); end
    drain(1200, "burst_drain");
    repeat (5) tick();
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b, required 1", empty[0]); end
    checks++; if (level[0] !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d, required 0", level[0]); end
  endtask

  task automatic test_timeout();
    act = 2'd1; lat = 0;
    put_byte(8'hB1, 1);
    put_byte(8'hB2, 2);
    wait_evt(100, "tmo_first");
    checks++; if (timeout[1] !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b, required 1", timeout[1]); end
    checks++; if (cyc - last_start != 64) begin errors++; $display("FAIL tmo_delay: got %0d, required 64", cyc - last_start); end
    tick();
    checks++; if (timeout[1] !== 1'b0) begin errors++; $display("FAIL tmo_single: got %b, required 0", timeout[1]); end
    wait_evt(100, "tmo_second");
    checks++; if (cyc - last_start != 64) begin errors++; $display("FAIL tmo_delay2: got %0d, required 64", cyc - last_start); end
    drain(20, "tmo_drain");
  endtask

  task automatic test_gap();
    int s0;
    act = 2'd2; lat = 20; s0 = n_start;
    put_byte(8'hC1, 1);
    put_byte(8'hC2, 2);
    wait_evt(100, "gap_over");
    repeat (3) tick();
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b, required 1", busy[2]); end
    spur = 1'b1;
    tick();
    spur = 1'b0;
    drain(100, "gap_drain");
    checks++; if (n_start - s0 != 2) begin errors++; $display("FAIL gap_starts: got %0d, required 2", n_start - s0); end
  endtask

  task automatic test_reset_mid();
    int s0;
    act = 2'd0; lat = 40;
    for (int i = 0; i < 6; i++) put_byte(8'hD0 + 8'(i), (i == 0) ? 1 : 0);
    checks++; if (level[0] !== 5'd5) begin errors++; $display("FAIL mid_level_pre: got %0d, required 5", level[0]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (level[0] !== 5'd0)   begin errors++; $display("FAIL mid_level: got %0d, required 0", level[0]); end
    checks++; if (empty[0] !== 1'b1)   begin errors++; $display("FAIL mid_empty: got %b, required 1", empty[0]); end
    checks++; if (busy[0] !== 1'b0)    begin errors++; $display("FAIL mid_busy: got %b, required 0", busy[0]); end
    checks++; if (tx_dat[0] !== 8'h00) begin errors++; $display("FAIL mid_tx_dat: got %h, required 00", tx_dat[0]); end
    s0 = n_start;
    wait_evt(60, "mid_late_over");
    repeat (5) tick();
    checks++; if (n_start != s0) begin errors++; $display("FAIL mid_no_start: got %0d starts, required 0", n_start - s0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_gap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
